// File: rtl/dmem_wb_slave.sv
// Single-port Wishbone data-memory slave with byte-lane writes and 0..3 wait states.
// Define DMEM_ADDR_ERR_EN to terminate out-of-range requests with wbs_err_o instead of wrapping.
module dmem_wb_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 2'd0 : 2'(WAIT_CYCLES - 1);

  logic [1:0]            state;
  logic [1:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_q;
  logic                  err_q;
  logic                  ack_q;
  logic [31:0]           rd_q;
  logic [31:0]           mem [DEPTH];

  logic [31:0] offset;
  logic        range_err;
  logic        req;
  logic        resp_end;
  logic        mem_wr;
  logic        mem_rd;

  assign offset   = wbs_addr_i - BASE_ADDR;
  assign req      = wbs_cyc_i & wbs_stb_i;
  // RESP only completes if the master still holds cyc; otherwise it is an abort.
  assign resp_end = (state == S_RESP) && wbs_cyc_i;
  assign mem_wr   = resp_end && we_q && !err_q;
  assign mem_rd   = resp_end && !we_q && !err_q;

`ifdef DMEM_ADDR_ERR_EN
  logic term_err_q;
  logic unused_addr_bits;

  assign range_err        = (wbs_addr_i < BASE_ADDR) || (|offset[31:ADDR_WIDTH+2]);
  assign unused_addr_bits = ^offset[1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) term_err_q <= 1'b0;
    else       term_err_q <= resp_end && err_q;
  end

  assign wbs_err_o = term_err_q;
`else
  logic unused_addr_bits;

  assign range_err        = 1'b0;
  assign unused_addr_bits = ^{offset[1:0], offset[31:ADDR_WIDTH+2]};
  assign wbs_err_o        = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= 2'd0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      dat_q    <= 32'h0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= resp_end && !err_q;
      case (state)
        S_IDLE: begin
          if (req) begin
            idx_q    <= offset[ADDR_WIDTH+1:2];
            we_q     <= wbs_we_i;
            sel_q    <= wbs_sel_i;
            dat_q    <= wbs_dat_i;
            err_q    <= range_err;
            wait_cnt <= 2'd0;
            state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wbs_cyc_i) begin
            wait_cnt <= 2'd0;
            state    <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 2'd0;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the array and its read register carry no reset so they map onto RAM and keep contents across rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_q[n]) mem[idx_q][8*n +: 8] <= dat_q[8*n +: 8];
      end
    end
    if (mem_rd) rd_q <= mem[idx_q];
  end

  // we_q still describes the finishing request during the termination cycle.
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = (ack_q && !we_q) ? rd_q : 32'h0;

endmodule

// File: tb/tb_dmem_wb_slave.sv
// Scoreboard bench for dmem_wb_slave: directed transactions on a WAIT_CYCLES=1 instance,
// plus back-to-back ack spacing on WAIT_CYCLES=0 and WAIT_CYCLES=3 instances.
module tb_dmem_wb_slave;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdat, rdat;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err;

  logic        cyc_b, stb_b;
  logic [31:0] rdat0, rdat3;
  logic        ack0, err0, ack3, err3;

  typedef struct {
    logic        is_err;
    logic        chk_data;
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;

  dmem_wb_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(W)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel), .wbs_we_i(we),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_dat_o(rdat), .wbs_ack_o(ack), .wbs_err_o(err)
  );

  dmem_wb_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst),
    .wbs_addr_i(32'h0), .wbs_dat_i(32'h0), .wbs_sel_i(4'h0), .wbs_we_i(1'b1),
    .wbs_cyc_i(cyc_b), .wbs_stb_i(stb_b),
    .wbs_dat_o(rdat0), .wbs_ack_o(ack0), .wbs_err_o(err0)
  );

  dmem_wb_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst),
    .wbs_addr_i(32'h0), .wbs_dat_i(32'h0), .wbs_sel_i(4'h0), .wbs_we_i(1'b1),
    .wbs_cyc_i(cyc_b), .wbs_stb_i(stb_b),
    .wbs_dat_o(rdat3), .wbs_ack_o(ack3), .wbs_err_o(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: pops one expectation per termination pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      check("ack_err_exclusive", {31'h0, ack & err}, 32'h0);
      if (!ack) check("dat_zero_without_ack", rdat, 32'h0);
      if (ack || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_termination", {31'h0, ack | err}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("term_is_err", {31'h0, err}, {31'h0, e.is_err});
          check("term_cycle", cyc_cnt, e.cycle);
          if (e.chk_data) check("read_data", rdat, e.data);
        end
      end
    end
  end

  task automatic present(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic exp_err, input logic [31:0] exp_data);
    exp_t e;
    present(w, a, d, s);
    e.is_err   = exp_err;
    e.chk_data = !w && !exp_err;
    e.data     = exp_data;
    e.cycle    = cyc_cnt + W + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_term();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack || err) return;
    end
    check("termination_timeout", 32'h0, 32'h1);
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic exp_err, input logic [31:0] exp_data);
    issue(w, a, d, s, exp_err, exp_data);
    wait_term();
    cyc = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn(1'b1, a, d, s, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_data);
    txn(1'b0, a, 32'h0, 4'hF, 1'b0, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, last0, last3, n0, n3;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 32'h0; wdat = 32'h0; sel = 4'h0;
    cyc_b = 1'b0; stb_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'h0, ack}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_dat", rdat, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Full-word write then read, then partial-lane and empty-lane writes.
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10, 32'hDEADBEEF);
    wr(32'h10, 32'h55555555, 4'b0010);
    rd(32'h10, 32'hDEAD55EF);
    wr(32'h10, 32'hFFFFFFFF, 4'b0000);
    rd(32'h10, 32'hDEAD55EF);
    rd(32'h13, 32'hDEAD55EF);
    wr(32'hFFC, 32'h11223344, 4'hF);
    rd(32'hFFC, 32'h11223344);
    wr(32'h20, 32'hCAFEF00D, 4'hF);

    // Drop cyc during WAIT: no termination, no write, next request accepted at once.
    present(1'b1, 32'h10, 32'h12345678, 4'hF);
    cyc = 1'b0;
    @(negedge clk);
    check("abort_no_ack", {31'h0, ack | err}, 32'h0);
    rd(32'h10, 32'hDEAD55EF);

    // Reset during WAIT of a write cancels it.
    present(1'b1, 32'h20, 32'hBADBAD00, 4'hF);
    rst = 1'b1;
    #1;
    check("rst_wait_ack", {31'h0, ack}, 32'h0);
    check("rst_wait_dat", rdat, 32'h0);
    cyc = 1'b0;
    @(negedge clk) rst = 1'b0;
    rd(32'h20, 32'hCAFEF00D);
    rd(32'hFFC, 32'h11223344);

    // Reset while a read is being acknowledged clears outputs asynchronously.
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAD55EF);
    wait_term();
    #1 rst = 1'b1;
    #1;
    check("rst_resp_ack", {31'h0, ack}, 32'h0);
    check("rst_resp_dat", rdat, 32'h0);
    cyc = 1'b0;
    @(negedge clk) rst = 1'b0;
    rd(32'h10, 32'hDEAD55EF);

    // Address 0x1000 is one past the last word of a 1024-word memory.
    wr(32'h0, 32'h0BADF00D, 4'hF);
`ifdef DMEM_ADDR_ERR_EN
    txn(1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0);
    rd(32'h0, 32'h0BADF00D);
    txn(1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 32'h0);
`else
    wr(32'h1000, 32'hA5A5A5A5, 4'hF);
    rd(32'h0, 32'hA5A5A5A5);
    rd(32'h1000, 32'hA5A5A5A5);
`endif

    // Back-to-back requests: acks every 2 cycles at WAIT_CYCLES=0, every 5 at WAIT_CYCLES=3.
    @(negedge clk);
    s = cyc_cnt;
    cyc_b = 1'b1; stb_b = 1'b1;
    last0 = -1; last3 = -1; n0 = 0; n3 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      check("w0_ack_err_exclusive", {31'h0, ack0 & err0}, 32'h0);
      check("w3_ack_err_exclusive", {31'h0, ack3 & err3}, 32'h0);
      if (ack0) begin
        check("w0_ack_cycle", cyc_cnt, (last0 < 0) ? s + 2 : last0 + 2);
        check("w0_write_dat_zero", rdat0, 32'h0);
        last0 = cyc_cnt; n0++;
      end
      if (ack3) begin
        check("w3_ack_cycle", cyc_cnt, (last3 < 0) ? s + 5 : last3 + 5);
        check("w3_write_dat_zero", rdat3, 32'h0);
        last3 = cyc_cnt; n3++;
      end
    end
    cyc_b = 1'b0; stb_b = 1'b0;
    check("w0_ack_count", n0, 15);
    check("w3_ack_count", n3, 6);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
